// File: rtl/alu_cmd_sequencer.sv
// Sequential front-end for the combinational 16-bit ALU: command FIFO, issue FSM, registered response.
// Optional saturating statistics counters are enabled with `define ALU_SEQ_STATS_EN.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_opa,
    input  logic [15:0] cmd_opb,
    input  logic        cmd_cin,
    output logic [2:0]  alu_sel,
    output logic [15:0] alu_opa,
    output logic [15:0] alu_opb,
    output logic        alu_cin,
    input  logic [15:0] alu_y1,
    input  logic [31:0] alu_y2,
    input  logic [15:0] alu_y3,
    input  logic        alu_cout,
    input  logic        alu_carry_out,
    input  logic        alu_m,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] stat_done_cnt,
    output logic [7:0]  stat_err_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_HOLD
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_SHIFT = 3'd3,
        OP_DIV   = 3'd4
    } op_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] opa;
        logic [15:0] opb;
        logic        cin;
    } cmd_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    settle_cnt;
    state_t        state;
    state_t        state_nx;
    logic          push;
    logic          pop;
    logic          capture;
    logic          handshake;
    logic          fifo_empty;
    cmd_t          head;
    logic [31:0]   pack_data;
    logic          pack_err;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr];
    assign rsp_valid  = (state == S_HOLD);
    assign handshake  = rsp_valid && rsp_ready;
    assign busy       = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, opa: cmd_opa, opb: cmd_opb, cin: cmd_cin};
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        capture  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_cnt == 4'd1) begin
                    capture  = 1'b1;
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        state_nx = S_DRIVE;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Packing is decoded from the registered opcode so it matches what the ALU is computing.
    always_comb begin
        pack_data = '0;
        pack_err  = 1'b0;
        case (alu_sel)
            OP_ADD:   pack_data = {15'b0, alu_cout, alu_y1};
            OP_SUB:   pack_data = {14'b0, alu_m, alu_carry_out, alu_y1};
            OP_MUL:   pack_data = alu_y2;
            OP_SHIFT: pack_data = {alu_y3, alu_y1};
            OP_DIV: begin
                pack_data = {alu_y3, alu_y1};
                pack_err  = (alu_opb == '0);
            end
            default:  pack_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            settle_cnt <= '0;
            alu_sel    <= '0;
            alu_opa    <= '0;
            alu_opb    <= '0;
            alu_cin    <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                alu_sel    <= head.op;
                alu_opa    <= head.opa;
                alu_opb    <= head.opb;
                alu_cin    <= head.cin;
                settle_cnt <= 4'(SETTLE_CYC);
            end else if (state == S_DRIVE && settle_cnt != 4'd1) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (capture) begin
                rsp_data <= pack_data;
                rsp_err  <= pack_err;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] done_q;
    logic [7:0]  err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= '0;
            err_q  <= '0;
        end else if (handshake) begin
            if (done_q != '1) begin
                done_q <= done_q + 16'd1;
            end
            if (rsp_err && err_q != '1) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign stat_done_cnt = done_q;
    assign stat_err_cnt  = err_q;
`else
    assign stat_done_cnt = '0;
    assign stat_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU model on the alu_* bus.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_opa;
    logic [15:0] cmd_opb;
    logic        cmd_cin;
    logic [2:0]  alu_sel;
    logic [15:0] alu_opa;
    logic [15:0] alu_opb;
    logic        alu_cin;
    logic [15:0] alu_y1;
    logic [31:0] alu_y2;
    logic [15:0] alu_y3;
    logic        alu_cout;
    logic        alu_carry_out;
    logic        alu_m;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [15:0] stat_done_cnt;
    logic [7:0]  stat_err_cnt;

    int tests = 0;
    int fails = 0;

    alu_cmd_sequencer #(.DEPTH(4), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_cin(cmd_cin),
        .alu_sel(alu_sel), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin),
        .alu_y1(alu_y1), .alu_y2(alu_y2), .alu_y3(alu_y3),
        .alu_cout(alu_cout), .alu_carry_out(alu_carry_out), .alu_m(alu_m),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy),
        .stat_done_cnt(stat_done_cnt), .stat_err_cnt(stat_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; sub carry_out is the borrow flag, divide by zero yields y1=FFFF, y3=a.
    logic [16:0] add_s;
    logic [15:0] diff;
    always_comb begin
        add_s         = {1'b0, alu_opa} + {1'b0, alu_opb} + 17'(alu_cin);
        diff          = alu_opa - alu_opb;
        alu_y1        = '0;
        alu_y2        = '0;
        alu_y3        = '0;
        alu_cout      = 1'b0;
        alu_carry_out = 1'b0;
        alu_m         = 1'b0;
        case (alu_sel)
            3'd0: begin
                alu_y1   = add_s[15:0];
                alu_cout = add_s[16];
            end
            3'd1: begin
                alu_y1        = diff;
                alu_carry_out = (alu_opa < alu_opb);
                alu_m         = (alu_opa[15] != alu_opb[15]) && (diff[15] != alu_opa[15]);
            end
            3'd2: alu_y2 = {16'b0, alu_opa} * {16'b0, alu_opb};
            3'd3: begin
                alu_y3 = alu_opa << alu_opb[3:0];
                alu_y1 = alu_opa >> alu_opb[3:0];
            end
            3'd4: begin
                if (alu_opb != '0) begin
                    alu_y1 = alu_opa / alu_opb;
                    alu_y3 = alu_opa % alu_opb;
                end else begin
                    alu_y1 = 16'hFFFF;
                    alu_y3 = alu_opa;
                end
            end
            default: begin
                alu_y1 = 16'hDEAD;
                alu_y2 = 32'hDEADBEEF;
                alu_y3 = 16'hBEEF;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
        cmd_op    = op;
        cmd_opa   = a;
        cmd_opb   = b;
        cmd_cin   = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] d, input logic e);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, rsp_data, d);
        chk({tag, "_err"}, 32'(rsp_err), 32'(e));
        if (rsp_ready) step();
    endtask

    initial begin
        logic saw_valid;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_opa   = '0;
        cmd_opb   = '0;
        cmd_cin   = 1'b0;
        rsp_ready = 1'b0;
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_opa", 32'(alu_opa), 32'd0);
        chk("rst_stat_done", 32'(stat_done_cnt), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Add with exact latency: valid two cycles after the accept edge.
        rsp_ready = 1'b1;
        send(3'd0, 16'd10, 16'd20, 1'b0);
        chk("add_lat0_valid", 32'(rsp_valid), 32'd0);
        chk("add_lat0_busy", 32'(busy), 32'd1);
        step();
        chk("add_lat1_valid", 32'(rsp_valid), 32'd0);
        chk("add_alu_opa", 32'(alu_opa), 32'd10);
        chk("add_alu_opb", 32'(alu_opb), 32'd20);
        step();
        chk("add_lat2_valid", 32'(rsp_valid), 32'd1);
        chk("add_data", rsp_data, 32'h0000001E);
        chk("add_err", 32'(rsp_err), 32'd0);
        step();
        chk("add_done_valid", 32'(rsp_valid), 32'd0);
        chk("add_done_busy", 32'(busy), 32'd0);

        // Mul then div back-to-back, in order.
        send(3'd2, 16'd8, 16'd8, 1'b0);
        send(3'd4, 16'd15, 16'd2, 1'b0);
        expect_rsp("mul", 32'h00000040, 1'b0);
        expect_rsp("div", 32'h00010007, 1'b0);

        send(3'd1, 16'd5, 16'd7, 1'b1);
        expect_rsp("sub", 32'h0001FFFE, 1'b0);

        send(3'd3, 16'hFF12, 16'd3, 1'b0);
        expect_rsp("shift", 32'hF8901FE2, 1'b0);

        // Backpressure: one in flight plus DEPTH queued fills the block.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(3'd0, 16'(i), 16'd100, 1'b0);
        end
        chk("bp_cmd_ready_full", 32'(cmd_ready), 32'd0);
        chk("bp_hold_data0", rsp_data, 32'h00000065);
        cmd_op    = 3'd0;
        cmd_opa   = 16'h0077;
        cmd_opb   = 16'd0;
        cmd_valid = 1'b1;
        step();
        step();
        cmd_valid = 1'b0;
        chk("bp_hold_data1", rsp_data, 32'h00000065);
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp_still_full", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            expect_rsp($sformatf("bp%0d", i), 32'(100 + i), 1'b0);
        end
        chk("bp_drained_busy", 32'(busy), 32'd0);
        chk("bp_drained_ready", 32'(cmd_ready), 32'd1);

        // Errors: illegal opcode and divide by zero.
        send(3'd6, 16'd1, 16'd2, 1'b0);
        expect_rsp("illegal", 32'h00000000, 1'b1);
        send(3'd4, 16'd9, 16'd0, 1'b0);
        expect_rsp("divzero", 32'h0009FFFF, 1'b1);
`ifdef ALU_SEQ_STATS_EN
        chk("stat_done", 32'(stat_done_cnt), 32'd12);
        chk("stat_err", 32'(stat_err_cnt), 32'd2);
`else
        chk("stat_done_off", 32'(stat_done_cnt), 32'd0);
        chk("stat_err_off", 32'(stat_err_cnt), 32'd0);
`endif

        // Reset while a command is in DRIVE with three more queued.
        rsp_ready = 1'b0;
        for (int i = 3; i <= 7; i++) begin
            send(3'd2, 16'(i), 16'd3, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_alu_opa", 32'(alu_opa), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mrst_alu_opa", 32'(alu_opa), 32'd0);
        chk("mrst_alu_sel", 32'(alu_sel), 32'd0);
        chk("mrst_rsp_data", rsp_data, 32'd0);
        chk("mrst_stat_done", 32'(stat_done_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            saw_valid = saw_valid | rsp_valid;
        end
        chk("mrst_no_stale", 32'(saw_valid), 32'd0);
        chk("mrst_idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
